sub_32_bit_bla_pipe: RTL and testbench

Two-stage pipelined 32-bit subtractor, the inverse-direction companion to the 32-bit carry-lookahead adder tree. It computes D = A - B - BIN using borrow generate/propagate lookahead, split as 16 low bits in stage 1 and 16 high bits in stage 2. Operands enter and results leave over valid/ready handshakes so the block can sit between ALU operand registers and the writeback path.

---
 rtl/sub_32_bit_bla_pipe.sv | 99 +++++++++
 tb/tb_sub_32_bit_bla_pipe.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sub_32_bit_bla_pipe.sv
// Two-stage 32-bit subtractor (D = A - B - BIN) using borrow lookahead.
// The low half is computed in stage 1 and the high half in stage 2; both stages use valid/ready handshakes.
module sub_32_bit_bla_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        BIN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] D,
  output logic        BOUT,
  output logic        V
);

  typedef struct packed {
    logic [15:0] dlo;
    logic        bmid;
    logic [15:0] ahi;
    logic [15:0] bhi;
  } s1_t;

  // 16-bit borrow-lookahead slice. Returns {borrow_out, diff}.
  function automatic logic [16:0] bla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    logic [15:0] g, p, bi;
    logic [3:0]  gg, gp;
    logic [4:0]  gb;
    logic        g10, p10, g32, p32;
    g = ~a & b;
    p = ~(a ^ b);
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & (g[4*k+2] | (p[4*k+2] &
              (g[4*k+1] | (p[4*k+1] & g[4*k])))));
      gp[k] = &p[4*k +: 4];
    end
    g10 = gg[1] | (gp[1] & gg[0]);
    p10 = gp[1] & gp[0];
    g32 = gg[3] | (gp[3] & gg[2]);
    p32 = gp[3] & gp[2];
    gb[0] = bin;
    gb[1] = gg[0] | (gp[0] & bin);
    gb[2] = g10 | (p10 & bin);
    gb[3] = gg[2] | (gp[2] & gb[2]);
    gb[4] = (g32 | (p32 & g10)) | (p32 & p10 & bin);
    // Inside each group, the borrow ripples from the group borrow-in.
    for (int k = 0; k < 4; k++) begin
      bi[4*k] = gb[k];
      for (int j = 1; j < 4; j++)
        bi[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & bi[4*k+j-1]);
    end
    return {gb[4], a ^ b ^ bi};
  endfunction

  logic        s1_valid;
  s1_t         s1;
  logic        s1_en, s2_en;
  logic [16:0] lo_res, hi_res;

  assign s2_en    = ~out_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;

  assign lo_res = bla16(A[15:0], B[15:0], BIN);
  assign hi_res = bla16(s1.ahi, s1.bhi, s1.bmid);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1        <= '0;
      out_valid <= 1'b0;
      D         <= '0;
      BOUT      <= 1'b0;
      V         <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1.dlo  <= lo_res[15:0];
          s1.bmid <= lo_res[16];
          s1.ahi  <= A[31:16];
          s1.bhi  <= B[31:16];
        end
      end
      // Bubbles advance the valid bit only; the held result stays put.
      if (s2_en) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          D    <= {hi_res[15:0], s1.dlo};
          BOUT <= hi_res[16];
          V    <= (s1.ahi[15] ^ s1.bhi[15]) & (hi_res[15] ^ s1.ahi[15]);
        end
      end
    end
  end

endmodule

// File: tb/tb_sub_32_bit_bla_pipe.sv
// Scoreboard bench for sub_32_bit_bla_pipe: it queues expected results when beats are accepted and pops them as results drain.
module tb_sub_32_bit_bla_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, BIN, out_valid, out_ready, BOUT, V;
  logic [31:0] A, B, D;
  logic        rnd_bp = 1'b0;

  typedef logic [33:0] exp_t;  // {BOUT, V, D}
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sub_32_bit_bla_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .BIN(BIN), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .BOUT(BOUT), .V(V)
  );

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] u;
    logic [33:0] s;
    u = {1'b0, a} - {1'b0, b} - 33'(bin);
    s = {{2{a[31]}}, a} - {{2{b[31]}}, b} - 34'(bin);
    return {u[32], s[32] ^ s[31], u[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bin);
    int t = 0;
    A = a; B = b; BIN = bin; in_valid = 1'b1;
    #1;
    while (!in_ready && t < 60) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) chk("accept_timeout", 34'(in_ready), 34'd1);
    else sbq.push_back(model(a, b, bin));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk); t++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 34'(sbq.size()), 34'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rnd_bp) out_ready = ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("spurious", 34'(out_valid), 34'd0);
      else begin
        e = sbq.pop_front();
        chk("result", {BOUT, V, D}, e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] va [5] = '{32'd5, 32'd0, 32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [31:0] vb [5] = '{32'd3, 32'd1, 32'd0,          32'd1,          32'hFFFF_FFFF};
  logic        vc [5] = '{1'b0,  1'b0,  1'b1,           1'b0,           1'b0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; BIN = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 34'(out_valid), 34'd0);
    chk("rst_result", {BOUT, V, D}, 34'd0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 34'(in_ready), 34'd1);
    @(negedge clk);

    // Latency and hand-checked constants.
    send(32'd5, 32'd3, 1'b0);
    chk("lat_early", 34'(out_valid), 34'd0);
    @(negedge clk);
    chk("lat_valid", 34'(out_valid), 34'd1);
    chk("simple_d", {BOUT, V, D}, {2'b00, 32'h0000_0002});
    drain();
    for (int i = 1; i < 5; i++) send(va[i], vb[i], vc[i]);
    drain();
    chk("ovf_last", {BOUT, V, D}, {2'b11, 32'h8000_0000});

    // Backpressure: two beats fill the pipe, the third waits.
    out_ready = 1'b0;
    send(32'd10, 32'd1, 1'b0);
    send(32'd20, 32'd2, 1'b0);
    A = 32'd30; B = 32'd3; BIN = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 34'(in_ready), 34'd0);
      chk("bp_out_valid", 34'(out_valid), 34'd1);
      chk("bp_hold_d", 34'(D), 34'd9);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 34'(in_ready), 34'd1);
    sbq.push_back(model(32'd30, 32'd3, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Random operands with random backpressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom; rb = $urandom;
      if (i % 7 == 0) ra = 32'h8000_0000;
      if (i % 11 == 0) rb = ra;
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset mid-stream discards in-flight beats.
    out_ready = 1'b0;
    send(32'd100, 32'd1, 1'b0);
    send(32'd200, 32'd2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    chk("mid_rst_out_valid", 34'(out_valid), 34'd0);
    chk("mid_rst_result", {BOUT, V, D}, 34'd0);
    #1 chk("mid_rst_in_ready", 34'(in_ready), 34'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale", 34'(out_valid), 34'd0);
    end
    send(32'd7, 32'd2, 1'b1);
    chk("post_rst_early", 34'(out_valid), 34'd0);
    @(negedge clk);
    chk("post_rst_valid", 34'(out_valid), 34'd1);
    chk("post_rst_d", {BOUT, V, D}, {2'b00, 32'd4});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
